vospi_packet_parser: RTL and testbench

- Byte-level VoSPI packet parser inside thermal_camera: sits between the SPI byte receiver (upstream) and the frame buffer writer (downstream).
- Consumes the 164-byte Lepton packets, strips ID/CRC, detects discard packets and packet-sequence errors.
- Emits 16-bit pixels tagged with row/column over a valid/ready interface.
- Flags frame completion after packet 59.

---
 rtl/vospi_pkg.sv | 28 ++
 rtl/vospi_packet_parser_pixel_out_reg.sv | 47 ++++
 rtl/vospi_packet_parser.sv | 188 ++++++++++++++++++
 tb/tb_vospi_packet_parser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vospi_pkg.sv
// Shared types and constants for the VoSPI packet parser.
//   state_t      : byte-position FSM states of one 164-byte VoSPI packet
//   pixel_t      : 16-bit pixel word, MSB byte received first
//   is_discard() : decodes the discard marker from the ID high byte
package vospi_pkg;

    typedef enum logic [2:0] {
        ST_ID_MSB,
        ST_ID_LSB,
        ST_CRC_MSB,
        ST_CRC_LSB,
        ST_PIX_MSB,
        ST_PIX_LSB,
        ST_DROP
    } state_t;

    localparam int          packet_bytes_c   = 164;
    localparam int          header_bytes_c   = 4;
    localparam logic [3:0]  discard_nibble_c = 4'hF;

    typedef logic [15:0] pixel_t;

    // Lepton marks discard packets with 0xF in the low nibble of ID byte 0.
    function automatic logic is_discard(input logic [3:0] id_nibble);
        return (id_nibble == discard_nibble_c);
    endfunction

endpackage

// File: rtl/vospi_packet_parser_pixel_out_reg.sv
// pixel_out_reg: single-entry valid/ready holding register for one pixel
// plus its row/column tag and an end-of-frame marker.
//   clk_i, reset_i (async, active-low)
//   load_i  + pixel_i/row_i/col_i/last_i : capture a new pixel
//   valid_o / ready_i                    : downstream handshake
//   pixel_o/row_o/col_o/last_o           : held pixel and tags
// A load in the same cycle as a downstream accept replaces the entry, so
// back-to-back pixels flow without a bubble.
module pixel_out_reg #(
    parameter int pw_p = 16,
    parameter int rw_p = 6,
    parameter int cw_p = 7
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [pw_p-1:0] pixel_i,
    input  logic [rw_p-1:0] row_i,
    input  logic [cw_p-1:0] col_i,
    input  logic            last_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [pw_p-1:0] pixel_o,
    output logic [rw_p-1:0] row_o,
    output logic [cw_p-1:0] col_o,
    output logic            last_o
);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_o <= 1'b0;
            pixel_o <= '0;
            row_o   <= '0;
            col_o   <= '0;
            last_o  <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            pixel_o <= pixel_i;
            row_o   <= row_i;
            col_o   <= col_i;
            last_o  <= last_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/vospi_packet_parser.sv
// vospi_packet_parser: turns a stream of VoSPI bytes into tagged pixels.
//   clk_i, reset_i (async, active-low)
//   byte_valid_i/byte_i/byte_ready_o      : upstream byte stream
//   pixel_valid_o/pixel_ready_i           : downstream pixel handshake
//   pixel_o/row_o/col_o                   : pixel {msb,lsb}, packet row, column
//   frame_done_o : pulse when pixel (last row, last col) is taken downstream
//   discard_o    : pulse on the last byte of a discard packet
//   sync_err_o   : pulse on the ID byte of an out-of-sequence packet
module vospi_packet_parser
    import vospi_pkg::*;
#(
    parameter int packet_bytes_p  = packet_bytes_c,
    parameter int frame_packets_p = 60,
    parameter int image_width_p   = 80,
    parameter int pixel_width_p   = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               byte_valid_i,
    input  logic [7:0]                         byte_i,
    output logic                               byte_ready_o,
    output logic                               pixel_valid_o,
    input  logic                               pixel_ready_i,
    output logic [pixel_width_p-1:0]           pixel_o,
    output logic [$clog2(frame_packets_p)-1:0] row_o,
    output logic [$clog2(image_width_p)-1:0]   col_o,
    output logic                               frame_done_o,
    output logic                               discard_o,
    output logic                               sync_err_o
);

    localparam int rw_c  = $clog2(frame_packets_p);
    localparam int cw_c  = $clog2(image_width_p);
    localparam int bcw_c = $clog2(packet_bytes_p);

    localparam logic [bcw_c-1:0] last_byte_c = bcw_c'(packet_bytes_p - 1);
    localparam logic [rw_c-1:0]  last_row_c  = rw_c'(frame_packets_p - 1);
    localparam logic [cw_c-1:0]  last_col_c  = cw_c'(image_width_p - 1);

    state_t           state_reg, state_next;
    logic [bcw_c-1:0] cnt_reg, cnt_next;
    logic [3:0]       id_nib_reg, id_nib_next;
    logic [7:0]       pix_msb_reg, pix_msb_next;
    logic [rw_c-1:0]  expected_reg, expected_next;
    logic [rw_c-1:0]  row_reg, row_next;
    logic             discard_reg, discard_next;

    logic             byte_accept;
    logic [11:0]      pkt_num;
    logic [bcw_c-1:0] pix_offset;
    logic [cw_c-1:0]  col_idx;
    pixel_t           pix_word;
    logic             load;
    logic             last_pix;
    logic             held_last;

    assign byte_ready_o = !(pixel_valid_o && !pixel_ready_i);
    assign byte_accept  = byte_valid_i && byte_ready_o;
    assign pkt_num      = {id_nib_reg, byte_i};
    assign pix_word     = {pix_msb_reg, byte_i};

    // Pixel LSB bytes sit at odd offsets 5,7,..; column = (offset-4)/2.
    assign pix_offset = cnt_reg - bcw_c'(header_bytes_c);
    assign col_idx    = cw_c'(pix_offset >> 1);
    assign last_pix   = (row_reg == last_row_c) && (col_idx == last_col_c);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= ST_ID_MSB;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_reg      <= '0;
            id_nib_reg   <= '0;
            pix_msb_reg  <= '0;
            expected_reg <= '0;
            row_reg      <= '0;
            discard_reg  <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            id_nib_reg   <= id_nib_next;
            pix_msb_reg  <= pix_msb_next;
            expected_reg <= expected_next;
            row_reg      <= row_next;
            discard_reg  <= discard_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        id_nib_next   = id_nib_reg;
        pix_msb_next  = pix_msb_reg;
        expected_next = expected_reg;
        row_next      = row_reg;
        discard_next  = discard_reg;
        load          = 1'b0;
        sync_err_o    = 1'b0;
        discard_o     = 1'b0;

        if (byte_accept) begin
            cnt_next = (cnt_reg == last_byte_c) ? '0 : cnt_reg + 1'b1;
            case (state_reg)
                ST_ID_MSB: begin
                    id_nib_next = byte_i[3:0];
                    state_next  = ST_ID_LSB;
                end
                ST_ID_LSB: begin
                    if (is_discard(id_nib_reg)) begin
                        discard_next = 1'b1;
                        state_next   = ST_CRC_MSB;
                    end else begin
                        discard_next = 1'b0;
                        if (pkt_num == 12'(expected_reg)) begin
                            row_next   = expected_reg;
                            state_next = ST_CRC_MSB;
                        end else if (pkt_num == 12'd0) begin
                            // Camera restarted its frame: resync on row 0.
                            sync_err_o    = 1'b1;
                            expected_next = '0;
                            row_next      = '0;
                            state_next    = ST_CRC_MSB;
                        end else begin
                            sync_err_o    = 1'b1;
                            expected_next = '0;
                            state_next    = ST_DROP;
                        end
                    end
                end
                ST_CRC_MSB: begin
                    state_next = ST_CRC_LSB;
                end
                ST_CRC_LSB: begin
                    state_next = discard_reg ? ST_DROP : ST_PIX_MSB;
                end
                ST_PIX_MSB: begin
                    pix_msb_next = byte_i;
                    state_next   = ST_PIX_LSB;
                end
                ST_PIX_LSB: begin
                    load = 1'b1;
                    if (cnt_reg == last_byte_c) begin
                        expected_next = (row_reg == last_row_c) ? '0 : row_reg + 1'b1;
                        state_next    = ST_ID_MSB;
                    end else begin
                        state_next = ST_PIX_MSB;
                    end
                end
                ST_DROP: begin
                    if (cnt_reg == last_byte_c) begin
                        discard_o  = discard_reg;
                        state_next = ST_ID_MSB;
                    end
                end
                default: begin
                    state_next = ST_ID_MSB;
                end
            endcase
        end
    end

    pixel_out_reg #(
        .pw_p (pixel_width_p),
        .rw_p (rw_c),
        .cw_p (cw_c)
    ) u_pixel_out_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load),
        .pixel_i (pixel_width_p'(pix_word)),
        .row_i   (row_reg),
        .col_i   (col_idx),
        .last_i  (last_pix),
        .ready_i (pixel_ready_i),
        .valid_o (pixel_valid_o),
        .pixel_o (pixel_o),
        .row_o   (row_o),
        .col_o   (col_o),
        .last_o  (held_last)
    );

    assign frame_done_o = pixel_valid_o && pixel_ready_i && held_last;

endmodule

// File: tb/tb_vospi_packet_parser.sv
// Directed bench for vospi_packet_parser: full frames, discard packets,
// sequence errors, downstream back-pressure and mid-packet reset.
module tb_vospi_packet_parser;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_ready_o;
    logic        pixel_valid_o;
    logic        pixel_ready_i = 1'b1;
    logic [15:0] pixel_o;
    logic [5:0]  row_o;
    logic [6:0]  col_o;
    logic        frame_done_o;
    logic        discard_o;
    logic        sync_err_o;

    vospi_packet_parser dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .byte_valid_i  (byte_valid_i),
        .byte_i        (byte_i),
        .byte_ready_o  (byte_ready_o),
        .pixel_valid_o (pixel_valid_o),
        .pixel_ready_i (pixel_ready_i),
        .pixel_o       (pixel_o),
        .row_o         (row_o),
        .col_o         (col_o),
        .frame_done_o  (frame_done_o),
        .discard_o     (discard_o),
        .sync_err_o    (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [28:0] exp_q[$];
    int pix_cnt, done_cnt, sync_cnt, disc_cnt, sync_idx, disc_idx, stall_cnt, cur_idx;
    bit rand_ready = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        pix_cnt = 0; done_cnt = 0; sync_cnt = 0; disc_cnt = 0;
        sync_idx = -1; disc_idx = -1; stall_cnt = 0;
    endtask

    // Called at negedge+1: inputs for the coming posedge are already stable.
    task automatic observe();
        logic [28:0] e;
        check_val("byte_ready", 32'(byte_ready_o), 32'(!(pixel_valid_o && !pixel_ready_i)));
        if (!byte_ready_o) stall_cnt++;
        if (pixel_valid_o && pixel_ready_i) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                check_val("extra_pixel", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("pixel", 32'({pixel_o, row_o, col_o}), 32'(e));
            end
        end
        if (frame_done_o) begin
            done_cnt++;
            check_val("done_coord", 32'({row_o, col_o}), 32'({6'd59, 7'd79}));
        end
        if (sync_err_o) begin sync_cnt++; sync_idx = cur_idx; end
        if (discard_o) begin disc_cnt++; disc_idx = cur_idx; end
    endtask

    task automatic drive_cycle(input logic valid, input logic [7:0] b);
        @(negedge clk_i);
        byte_valid_i  = valid;
        byte_i        = b;
        pixel_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        observe();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        do begin
            drive_cycle(1'b1, b);
            w++;
        end while (!byte_ready_o && w < 64);
        if (!byte_ready_o) check_val("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit saved = rand_ready;
        rand_ready = 1'b0;
        repeat (n) drive_cycle(1'b0, 8'h00);
        rand_ready = saved;
    endtask

    // Pixel data bytes are {packet-number low byte, column}; exp_row < 0
    // means the packet must produce no pixels.
    task automatic send_packet(input logic [15:0] id, input int exp_row, input int nbytes);
        logic [7:0] b;
        if (exp_row >= 0) begin
            for (int c = 0; c < 80; c++)
                exp_q.push_back({id[7:0], 8'(c), 6'(exp_row), 7'(c)});
        end
        for (int i = 0; i < nbytes; i++) begin
            if (i == 0)          b = id[15:8];
            else if (i == 1)     b = id[7:0];
            else if (i < 4)      b = 8'hC3;
            else if (i % 2 == 0) b = id[7:0];
            else                 b = 8'((i - 5) / 2);
            cur_idx = i;
            send_byte(b);
        end
        $display("packet id=%04h bytes=%0d exp_row=%0d", id, nbytes, exp_row);
    endtask

    task automatic send_frame();
        for (int p = 0; p < 60; p++) send_packet(16'(p), p, 164);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        byte_valid_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_counts();
        cur_idx = 0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check_val("rst_pixel_valid", 32'(pixel_valid_o), 32'd0);
        check_val("rst_byte_ready", 32'(byte_ready_o), 32'd1);
        check_val("rst_frame_done", 32'(frame_done_o), 32'd0);
        check_val("rst_discard", 32'(discard_o), 32'd0);
        check_val("rst_sync_err", 32'(sync_err_o), 32'd0);

        // Full frame, downstream always ready.
        clear_counts();
        send_frame();
        idle(4);
        check_val("frame1_pixels", 32'(pix_cnt), 32'd4800);
        check_val("frame1_done", 32'(done_cnt), 32'd1);
        check_val("frame1_sync", 32'(sync_cnt), 32'd0);
        check_val("frame1_qempty", 32'(exp_q.size()), 32'd0);

        // Discard packet between frames, then packet 0 accepted.
        clear_counts();
        send_packet(16'h0F00, -1, 164);
        send_packet(16'h0000, 0, 164);
        idle(4);
        check_val("disc_count", 32'(disc_cnt), 32'd1);
        check_val("disc_byte", 32'(disc_idx), 32'd163);
        check_val("disc_pixels", 32'(pix_cnt), 32'd80);
        check_val("disc_sync", 32'(sync_cnt), 32'd0);

        // Packet 1 ok, packet 3 out of sequence, then packet 0 accepted.
        clear_counts();
        send_packet(16'h0001, 1, 164);
        send_packet(16'h0003, -1, 164);
        send_packet(16'h0000, 0, 164);
        idle(4);
        check_val("seq_sync_count", 32'(sync_cnt), 32'd1);
        check_val("seq_sync_byte", 32'(sync_idx), 32'd1);
        check_val("seq_pixels", 32'(pix_cnt), 32'd160);
        check_val("seq_qempty", 32'(exp_q.size()), 32'd0);

        // Packet 0 while expecting 1: error, but accepted as row 0.
        clear_counts();
        send_packet(16'h0000, 0, 164);
        idle(4);
        check_val("restart_sync", 32'(sync_cnt), 32'd1);
        check_val("restart_pixels", 32'(pix_cnt), 32'd80);

        // Full frame with random downstream back-pressure.
        do_reset();
        clear_counts();
        rand_ready = 1'b1;
        send_frame();
        rand_ready = 1'b0;
        idle(4);
        check_val("bp_pixels", 32'(pix_cnt), 32'd4800);
        check_val("bp_done", 32'(done_cnt), 32'd1);
        check_val("bp_sync", 32'(sync_cnt), 32'd0);
        check_val("bp_stalled", 32'(stall_cnt > 0), 32'd1);
        check_val("bp_qempty", 32'(exp_q.size()), 32'd0);

        // Reset at byte 90 of packet 5, then a fresh frame.
        do_reset();
        clear_counts();
        for (int p = 0; p < 5; p++) send_packet(16'(p), p, 164);
        send_packet(16'h0005, 5, 90);
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        byte_valid_i = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(pixel_valid_o), 32'd0);
        check_val("mid_rst_ready", 32'(byte_ready_o), 32'd1);
        check_val("mid_rst_done", 32'(frame_done_o), 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        reset_i = 1'b1;
        clear_counts();
        send_frame();
        idle(4);
        check_val("post_rst_pixels", 32'(pix_cnt), 32'd4800);
        check_val("post_rst_done", 32'(done_cnt), 32'd1);
        check_val("post_rst_sync", 32'(sync_cnt), 32'd0);
        check_val("post_rst_qempty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
